// File: rtl/td4_pkg.sv
// Shared types and widths for the TD4 4-bit computer: opcodes, sequencer
// states and decoder select encodings.
package td4_pkg;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;
  localparam int ROM_W   = 10;

  typedef enum logic [3:0] {
    OP_ADD_A   = 4'b0000,
    OP_MOV_AB  = 4'b0001,
    OP_IN_A    = 4'b0010,
    OP_MOV_AI  = 4'b0011,
    OP_MOV_BA  = 4'b0100,
    OP_ADD_B   = 4'b0101,
    OP_IN_B    = 4'b0110,
    OP_MOV_BI  = 4'b0111,
    OP_OUT_B   = 4'b1001,
    OP_OUT_I   = 4'b1011,
    OP_JNC     = 4'b1110,
    OP_JMP     = 4'b1111
  } opcode_e;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_A    = 2'd1,
    DST_B    = 2'd2
  } dst_e;

  typedef enum logic [1:0] {
    SRC_IMM = 2'd0,
    SRC_A   = 2'd1,
    SRC_B   = 2'd2
  } src_e;

endpackage

// File: rtl/td4_decode.sv
// Combinational instruction decoder: turns the latched instruction word into
// register selects and per-class strobes for the execute datapath.
module td4_decode
  import td4_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output dst_e               dst_sel,
  output src_e               src_sel,
  output logic               is_add,
  output logic               is_out,
  output logic               is_jmp,
  output logic               is_jnc,
  output logic               is_in
);

  // Unlisted opcodes fall through the defaults and behave as NOP.
  always_comb begin
    dst_sel = DST_NONE;
    src_sel = SRC_IMM;
    is_add  = 1'b0;
    is_out  = 1'b0;
    is_jmp  = 1'b0;
    is_jnc  = 1'b0;
    is_in   = 1'b0;
    case (opcode_e'(ir[7:4]))
      OP_ADD_A:  begin dst_sel = DST_A; is_add = 1'b1; end
      OP_ADD_B:  begin dst_sel = DST_B; is_add = 1'b1; end
      OP_MOV_AI: dst_sel = DST_A;
      OP_MOV_BI: dst_sel = DST_B;
      OP_MOV_AB: begin dst_sel = DST_A; src_sel = SRC_B; end
      OP_MOV_BA: begin dst_sel = DST_B; src_sel = SRC_A; end
      OP_IN_A:   begin dst_sel = DST_A; is_in = 1'b1; end
      OP_IN_B:   begin dst_sel = DST_B; is_in = 1'b1; end
      OP_OUT_B:  begin is_out = 1'b1; src_sel = SRC_B; end
      OP_OUT_I:  is_out = 1'b1;
      OP_JMP:    is_jmp = 1'b1;
      OP_JNC:    is_jnc = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4_fetch_exec.sv
// Two-phase fetch/execute sequencer for the TD4: drives the ROM address,
// latches the instruction, and executes it against A, B, carry and out_port.
module td4_fetch_exec
  import td4_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC               = 4'd0,
  parameter bit                CLEAR_CARRY_ON_NON_ADD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              carry,
  output logic              exec_phase
);

  state_e              state, next_state;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   imm, dst_val, src_val, result;
  logic [DATA_W:0]     sum;
  logic                jump_taken;
  logic                unused_rom_bits;

  dst_e dst_sel;
  src_e src_sel;
  logic is_add, is_out, is_jmp, is_jnc, is_in;

  td4_decode u_decode (
    .ir      (ir),
    .dst_sel (dst_sel),
    .src_sel (src_sel),
    .is_add  (is_add),
    .is_out  (is_out),
    .is_jmp  (is_jmp),
    .is_jnc  (is_jnc),
    .is_in   (is_in)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else if (en) state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   next_state = EXEC;
      EXEC:    next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    exec_phase = (state == EXEC);
  end

  assign rom_addr        = pc;
  assign imm             = ir[3:0];
  assign unused_rom_bits = ^rom_data[ROM_W-1:INSTR_W];

  // Operands are all pre-edge values, so ADD A reads the old A.
  always_comb begin
    dst_val = (dst_sel == DST_B) ? reg_b : reg_a;
    case (src_sel)
      SRC_A:   src_val = reg_a;
      SRC_B:   src_val = reg_b;
      default: src_val = imm;
    endcase
    if (is_in) src_val = in_port;
    sum        = {1'b0, dst_val} + {1'b0, imm};
    result     = is_add ? sum[DATA_W-1:0] : src_val;
    jump_taken = is_jmp | (is_jnc & ~carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      out_port <= '0;
      carry    <= 1'b0;
    end else if (en) begin
      if (state == FETCH) begin
        ir <= rom_data[INSTR_W-1:0];
      end else begin
        if (dst_sel == DST_A) reg_a <= result;
        if (dst_sel == DST_B) reg_b <= result;
        if (is_out) out_port <= src_val;
        if (is_add) carry <= sum[DATA_W];
        else if (CLEAR_CARRY_ON_NON_ADD) carry <= 1'b0;
        pc <= jump_taken ? imm : pc + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_td4_fetch_exec.sv
// Directed self-checking bench for td4_fetch_exec with a behavioural ROM
// whose unused top bits can be driven independently.
module tb_td4_fetch_exec;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] rom_addr;
  logic [9:0] rom_data;
  logic [3:0] in_port = 4'd0;
  logic [3:0] out_port, reg_a, reg_b;
  logic       carry, exec_phase;

  logic [7:0] rom [16];
  logic [1:0] hi_bits = 2'b00;

  int checks = 0;
  int errors = 0;

  assign rom_data = {hi_bits, rom[rom_addr]};

  always #5 clk = ~clk;

  td4_fetch_exec dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .in_port    (in_port),
    .out_port   (out_port),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .carry      (carry),
    .exec_phase (exec_phase)
  );

  // Advance n clock edges, leaving the bench 1 time unit past the last edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 8'h35;
    do_reset();
    checks++;
    if ({rom_addr, reg_a, reg_b, out_port, carry, exec_phase} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got pc=%0d a=%0d b=%0d out=%0d c=%0b ex=%0b, want all 0",
               rom_addr, reg_a, reg_b, out_port, carry, exec_phase);
    end
    applyStimulus(1);
    checks++;
    if (exec_phase !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_fetch_phase: got %0b want 1", exec_phase);
    end
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checks++;
    if (reg_a !== 4'd0 || rom_addr !== 4'd0 || exec_phase !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_abort: got a=%0d pc=%0d ex=%0b want a=0 pc=0 ex=0",
               reg_a, rom_addr, exec_phase);
    end
  endtask

  task automatic test_add_carry();
    clear_rom();
    rom[0] = 8'h35;
    rom[1] = 8'h0C;
    rom[2] = 8'hE0;
    do_reset();
    applyStimulus(2);
    checks++;
    if (reg_a !== 4'd5 || carry !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mov_a_imm: got a=%0d c=%0b want a=5 c=0", reg_a, carry);
    end
    applyStimulus(2);
    checks++;
    if (reg_a !== 4'd1 || carry !== 1'b1 || rom_addr !== 4'd2) begin
      errors++;
      $display("[TB] FAIL add_overflow: got a=%0d c=%0b pc=%0d want a=1 c=1 pc=2",
               reg_a, carry, rom_addr);
    end
    applyStimulus(2);
    checks++;
    if (rom_addr !== 4'd3 || carry !== 1'b0 || reg_a !== 4'd1) begin
      errors++;
      $display("[TB] FAIL jnc_not_taken: got pc=%0d c=%0b a=%0d want pc=3 c=0 a=1",
               rom_addr, carry, reg_a);
    end
  endtask

  // Continues from test_add_carry with pc=3.
  task automatic test_jump_wrap();
    rom[3]  = 8'hFF;
    rom[15] = 8'h80;
    applyStimulus(2);
    checks++;
    if (rom_addr !== 4'd15) begin
      errors++;
      $display("[TB] FAIL jmp_taken: got pc=%0d want 15", rom_addr);
    end
    applyStimulus(2);
    checks++;
    if (rom_addr !== 4'd0 || reg_a !== 4'd1) begin
      errors++;
      $display("[TB] FAIL pc_wrap: got pc=%0d a=%0d want pc=0 a=1", rom_addr, reg_a);
    end
  endtask

  task automatic test_io();
    clear_rom();
    rom[0] = 8'h60;
    rom[1] = 8'h90;
    rom[2] = 8'hB6;
    in_port = 4'd9;
    do_reset();
    applyStimulus(2);
    in_port = 4'd3;
    checks++;
    if (reg_b !== 4'd9 || out_port !== 4'd0) begin
      errors++;
      $display("[TB] FAIL in_b: got b=%0d out=%0d want b=9 out=0", reg_b, out_port);
    end
    applyStimulus(2);
    in_port = 4'd12;
    checks++;
    if (out_port !== 4'd9 || reg_b !== 4'd9) begin
      errors++;
      $display("[TB] FAIL out_b: got out=%0d b=%0d want out=9 b=9", out_port, reg_b);
    end
    applyStimulus(2);
    checks++;
    if (out_port !== 4'd6 || reg_b !== 4'd9) begin
      errors++;
      $display("[TB] FAIL out_imm: got out=%0d b=%0d want out=6 b=9", out_port, reg_b);
    end
  endtask

  task automatic test_stall();
    clear_rom();
    rom[0] = 8'h53;
    do_reset();
    applyStimulus(1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checks++;
      if (exec_phase !== 1'b1 || reg_b !== 4'd0 || rom_addr !== 4'd0) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got ex=%0b b=%0d pc=%0d want ex=1 b=0 pc=0",
                 i, exec_phase, reg_b, rom_addr);
      end
    end
    en = 1'b1;
    applyStimulus(1);
    checks++;
    if (reg_b !== 4'd3 || exec_phase !== 1'b0 || rom_addr !== 4'd1) begin
      errors++;
      $display("[TB] FAIL stall_resume: got b=%0d ex=%0b pc=%0d want b=3 ex=0 pc=1",
               reg_b, exec_phase, rom_addr);
    end
  endtask

  // MOV A,14; ADD A,5 (A=3,c=1); MOV B,A (c cleared); OUT B -- with noisy [9:8].
  task automatic test_ignored_bits();
    logic [3:0] exp_a [8];
    logic [3:0] exp_b [8];
    logic [3:0] exp_o [8];
    logic       exp_c [8];
    exp_a = '{4'd0, 4'd14, 4'd14, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
    exp_b = '{4'd0, 4'd0,  4'd0,  4'd0, 4'd0, 4'd3, 4'd3, 4'd3};
    exp_o = '{4'd0, 4'd0,  4'd0,  4'd0, 4'd0, 4'd0, 4'd0, 4'd3};
    exp_c = '{1'b0, 1'b0,  1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    clear_rom();
    rom[0] = 8'h3E;
    rom[1] = 8'h05;
    rom[2] = 8'h40;
    rom[3] = 8'h90;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      hi_bits = 2'($urandom_range(0, 3));
      applyStimulus(1);
      checks++;
      if (reg_a !== exp_a[i] || reg_b !== exp_b[i] || out_port !== exp_o[i] || carry !== exp_c[i]) begin
        errors++;
        $display("[TB] FAIL hi_bits_trace[%0d]: got a=%0d b=%0d out=%0d c=%0b want a=%0d b=%0d out=%0d c=%0b",
                 i, reg_a, reg_b, out_port, carry, exp_a[i], exp_b[i], exp_o[i], exp_c[i]);
      end
    end
    hi_bits = 2'b00;
    checks++;
    if (rom_addr !== 4'd4) begin
      errors++;
      $display("[TB] FAIL hi_bits_pc: got %0d want 4", rom_addr);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_jump_wrap();
    test_io();
    test_stall();
    test_ignored_bits();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_fetch_exec.md
Name: td4_fetch_exec

Overview:
- Instruction fetch/execute sequencer for the 4-bit computer. It is the consumer side of the control ROM.
- Drives the 4-bit ROM address (program counter) and registers the returned instruction word.
- Decodes the opcode and executes it against registers A, B, the carry flag and the I/O ports.
- Two-phase machine: FETCH then EXEC, one instruction per two enabled cycles.

Parameters:
- RESET_PC, 4'd0, program counter value loaded on reset.
- CLEAR_CARRY_ON_NON_ADD, 1, when 1 every non-ADD instruction clears carry; when 0 carry holds.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; when 0 all state holds.
- rom_addr  output  4  program counter driven to the control ROM.
- rom_data  input  10  ROM word; only [7:0] used: [7:4] opcode, [3:0] immediate; [9:8] ignored.
- in_port  input  4  external input, sampled in EXEC of IN instructions.
- out_port  output  4  registered output port.
- reg_a  output  4  register A (debug/observe).
- reg_b  output  4  register B (debug/observe).
- carry  output  1  carry flag.
- exec_phase  output  1  1 while state is EXEC.

Behaviour:
- Reset (rst=1 at a rising edge, overrides en): pc=RESET_PC, state=FETCH, ir=0, A=B=0, out_port=0, carry=0, exec_phase=0.
- A reset asserted during EXEC aborts the instruction with no register write.
- rom_addr = pc at all times (registered value). The ROM path is combinational, so rom_data is valid in the same cycle.
- FETCH, en=1: ir <= rom_data[7:0]; state <= EXEC. No other state changes.
- EXEC, en=1: execute ir; state <= FETCH; pc <= pc+1 (mod 16) unless a jump is taken, in which case pc <= imm.
- en=0 in either state: all registers hold, including state, pc and ir.
- Latency: results are visible the cycle after the EXEC edge, 2 enabled cycles per instruction.
- Opcodes (imm = ir[3:0]):
  - 0000 ADD A,imm: {carry,A} <= A+imm (5-bit).
  - 0101 ADD B,imm: {carry,B} <= B+imm.
  - 0011 MOV A,imm.
  - 0111 MOV B,imm.
  - 0001 MOV A,B.
  - 0100 MOV B,A.
  - 0010 IN A: A <= in_port.
  - 0110 IN B: B <= in_port.
  - 1001 OUT B: out_port <= B.
  - 1011 OUT imm: out_port <= imm.
  - 1111 JMP imm.
  - 1110 JNC imm: taken iff carry==0 at EXEC.
  - All other opcodes are NOP (pc+1, no register change).
- Carry:
  - Written only by ADD when CLEAR_CARRY_ON_NON_ADD=0.
  - Otherwise it is cleared by every other executed instruction, including NOP and JNC.
  - JNC evaluates the old carry before clearing it.
- Wrap-around: pc 15 +1 -> 0. 4-bit adds wrap, with the overflow bit going to carry.
- Writes to the same register read by the instruction (e.g. ADD A) use the pre-edge value; there is exactly one write per register per EXEC.
- in_port is sampled only on the EXEC edge of an IN instruction; changes at any other time have no effect.

Decomposition:
- Shared package td4_pkg holds:
  - opcode_e enum: 4-bit encodings above.
  - state_e enum: FETCH, EXEC.
  - Widths: DATA_W=4, ADDR_W=4, INSTR_W=8, ROM_W=10.
- One sub-module, td4_decode: combinational; ir -> {dst_sel, src_sel, is_add, is_out, is_jmp, is_jnc, is_in}.
- td4_fetch_exec keeps the sequencing, registers and datapath.

Test Plan:
1. Reset: hold rst 2 cycles with en=1 -> rom_addr=0, A=B=0, out_port=0, carry=0, exec_phase=0. Assert rst during EXEC of MOV A,5 (0x35) -> A stays 0, pc=0.
2. Arithmetic/carry: ROM[0]=0x35, ROM[1]=0x0C, ROM[2]=0xE0 -> after 4 enabled cycles A=1, carry=1; JNC not taken, pc=3, carry cleared to 0.
3. Taken jump and wrap: ROM[3]=0xFF, ROM[15]=NOP (0x80) -> pc goes 3 -> 15 -> 0; rom_addr shows 15 then 0.
4. I/O: in_port=9; ROM[0]=0x60 (IN B), ROM[1]=0x90 (OUT B), ROM[2]=0xB6 (OUT 6) -> out_port=9 the cycle after the 2nd EXEC, then 6 after the 3rd. Toggling in_port after IN has no effect.
5. Enable stall: drop en for 5 cycles while in EXEC of ADD B,3 -> exec_phase stays 1, B unchanged; B=3 one enabled cycle after en returns.
6. rom_data[9:8] toggled randomly while ROM[0..3] are fixed -> register trace identical to the run with [9:8]=0.
